// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions: transfer/size codes, DMA state encoding and
// the element alignment rule used by bus masters.
package ahbl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_FIN,
    ST_ERR
  } dma_state_e;

  // True when an element of size code sz may start at a byte address ending in lo.
  function automatic logic addr_aligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   addr_aligned = 1'b1;
      2'b01:   addr_aligned = ~lo[0];
      2'b10:   addr_aligned = (lo == 2'b00);
      default: addr_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahbl_lane_align.sv
// Byte-lane steering for a 32-bit little-endian AHB master: pulls an element
// out of its read lane and replicates a write element across all lanes.
module ahbl_lane_align
  import ahbl_pkg::*;
(
  input  logic [2:0]        size_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] wbuf_i,
  output logic [DATA_W-1:0] rd_elem_c,
  output logic [DATA_W-1:0] wdata_c
);

  always_comb begin
    rd_elem_c = rdata_i;
    wdata_c   = wbuf_i;
    case (size_i)
      HSIZE_BYTE: begin
        rd_elem_c = {24'h0, rdata_i[{addr_lo_i, 3'b000} +: 8]};
        wdata_c   = {4{wbuf_i[7:0]}};
      end
      HSIZE_HALF: begin
        rd_elem_c = {16'h0, rdata_i[{addr_lo_i[1], 4'b0000} +: 16]};
        wdata_c   = {2{wbuf_i[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahbl_dma_master.sv
// Single-channel, non-pipelined AHB-Lite copy engine: one read beat then one
// write beat per element, with all bus and status outputs registered.
module ahbl_dma_master
  import ahbl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [1:0]        size,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HRESP
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [2:0]        hsize_q, hsize_d;
  logic              hwrite_q, hwrite_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic [DATA_W-1:0] rd_elem_c, wdata_c;
  logic [ADDR_W-1:0] step_c;

  assign step_c = ADDR_W'(1) << size_q;

  ahbl_lane_align u_lane (
    .size_i    ({1'b0, size_q}),
    .addr_lo_i (src_q[1:0]),
    .rdata_i   (HRDATA),
    .wbuf_i    (buf_q),
    .rd_elem_c (rd_elem_c),
    .wdata_c   (wdata_c)
  );

  // Sequencing; bus outputs are decoded from the next state so they are
  // valid in the first cycle of each phase.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    buf_d   = buf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          cnt_d  = count;
          size_d = size;
          if (!(addr_aligned(size, src_addr[1:0]) && addr_aligned(size, dst_addr[1:0])))
            state_d = ST_ERR;
          else if (count == '0)
            state_d = ST_FIN;
          else
            state_d = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: if (HREADY) state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (HRESP) begin
          state_d = ST_ERR;
        end else if (HREADY) begin
          buf_d   = rd_elem_c;
          state_d = ST_WR_ADDR;
        end
      end
      ST_WR_ADDR: if (HREADY) state_d = ST_WR_DATA;
      ST_WR_DATA: begin
        if (HRESP) begin
          state_d = ST_ERR;
        end else if (HREADY) begin
          src_d   = src_q + step_c;
          dst_d   = dst_q + step_c;
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? ST_FIN : ST_RD_ADDR;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    htrans_d = HTRANS_IDLE;
    haddr_d  = haddr_q;
    hsize_d  = hsize_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    case (state_d)
      ST_RD_ADDR: begin
        htrans_d = HTRANS_NONSEQ;
        haddr_d  = src_d;
        hsize_d  = {1'b0, size_d};
        hwrite_d = 1'b0;
      end
      ST_WR_ADDR: begin
        htrans_d = HTRANS_NONSEQ;
        haddr_d  = dst_d;
        hsize_d  = {1'b0, size_d};
        hwrite_d = 1'b1;
      end
      ST_WR_DATA: hwdata_d = wdata_c;
      default: ;
    endcase

    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_FIN);
    error_d = (state_d == ST_ERR);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      buf_q    <= '0;
      haddr_q  <= '0;
      htrans_q <= HTRANS_IDLE;
      hsize_q  <= '0;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      buf_q    <= buf_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hsize_q  <= hsize_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign HADDR  = haddr_q;
  assign HTRANS = htrans_q;
  assign HSIZE  = hsize_q;
  assign HWRITE = hwrite_q;
  assign HWDATA = hwdata_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;

endmodule

// File: tb/tb_ahbl_dma_master.sv
// Bench for ahbl_dma_master: byte-addressed memory slave with wait/error
// injection, expected-transfer queue built from job parameters, cycle checks.
`timescale 1ns/1ps
module tb_ahbl_dma_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] count = '0;
  logic [1:0]  size = '0;
  logic        busy, done, error;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA = '0;
  logic        HRESP = 1'b0;

  ahbl_dma_master #(.CNT_W(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .count(count), .size(size), .busy(busy), .done(done),
    .error(error), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] data;
  } xfer_t;

  xfer_t       q[$];
  xfer_t       cur, dp;
  logic [7:0]  mem [0:1023];
  int          cyc = 0;
  int          checks = 0, errors = 0;
  int          exp_t = 0, exp_end = 0, exp_kind = 0;  // kind: 1 done, 2 error
  int          ws = 0, err_rd = -1, rd_idx = 0, wcnt = 0;
  bit          ap_active = 0, dp_valid = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem32(input logic [31:0] a);
    logic [9:0] b;
    b = {a[9:2], 2'b00};
    return {mem[b | 10'd3], mem[b | 10'd2], mem[b | 10'd1], mem[b]};
  endfunction

  task automatic wr32(input logic [31:0] a, input logic [31:0] v);
    for (int b = 0; b < 4; b++) begin
      logic [31:0] ab;
      ab = a + 32'(b);
      mem[ab[9:0]] = v[8*b +: 8];
    end
  endtask

  // Expected bus transfers for a job: read then write per element, stopping
  // after the read that will be answered with an error.
  task automatic build(input logic [31:0] s, input logic [31:0] d, input logic [1:0] sz,
                       input int n, input int err_el);
    logic [31:0] step, e, a;
    xfer_t x;
    step = 32'd1 << sz;
    q.delete();
    rd_idx = 0;
    err_rd = err_el;
    for (int i = 0; i < n; i++) begin
      a = s + step * 32'(i);
      x.addr = a; x.wr = 1'b0; x.sz = {1'b0, sz}; x.data = '0;
      q.push_back(x);
      if (i == err_el) break;
      e = '0;
      for (int b = 0; b < int'(step); b++) begin
        logic [31:0] ab;
        ab = a + 32'(b);
        e[8*b +: 8] = mem[ab[9:0]];
      end
      case (sz)
        2'b00:   e = {4{e[7:0]}};
        2'b01:   e = {2{e[15:0]}};
        default: ;
      endcase
      x.addr = d + step * 32'(i); x.wr = 1'b1; x.data = e;
      q.push_back(x);
    end
  endtask

  // Per-cycle status checks plus the memory slave, evaluated mid-cycle.
  always @(negedge HCLK) begin
    chk("busy", 32'(busy), 32'((cyc > exp_t) && (cyc <= exp_end)));
    chk("done", 32'(done), 32'((cyc == exp_end) && (exp_kind == 1)));
    chk("error", 32'(error), 32'((cyc == exp_end) && (exp_kind == 2)));
    if (!HRESETn) begin
      HREADY = 1'b1; HRESP = 1'b0; dp_valid = 0; ap_active = 0; wcnt = 0;
    end else begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      if (dp_valid) begin
        chk("htrans_in_data_phase", 32'(HTRANS), 32'h0);
        if (wcnt < ws) begin
          HREADY = 1'b0;
          wcnt++;
        end else begin
          wcnt = 0;
          dp_valid = 0;
          if (!dp.wr) begin
            if (rd_idx == err_rd) HRESP = 1'b1;
            else HRDATA = mem32(dp.addr);
            rd_idx++;
          end else begin
            chk("hwdata", HWDATA, dp.data);
            for (int b = 0; b < (1 << dp.sz); b++) begin
              logic [31:0] ab;
              ab = dp.addr + 32'(b);
              mem[ab[9:0]] = HWDATA[{ab[1:0], 3'b000} +: 8];
            end
          end
        end
      end else if (HTRANS == 2'b10) begin
        if (!ap_active) begin
          ap_active = 1;
          chk("xfer_expected", 32'(q.size() != 0), 32'h1);
          if (q.size() != 0) begin
            cur = q.pop_front();
            chk("haddr", HADDR, cur.addr);
            chk("hwrite", 32'(HWRITE), 32'(cur.wr));
            chk("hsize", 32'(HSIZE), 32'(cur.sz));
          end else begin
            cur.addr = HADDR; cur.wr = HWRITE; cur.sz = HSIZE; cur.data = HWDATA;
          end
        end else begin
          chk("haddr_hold", HADDR, cur.addr);
          chk("hwrite_hold", 32'(HWRITE), 32'(cur.wr));
          chk("hsize_hold", 32'(HSIZE), 32'(cur.sz));
        end
        if (wcnt < ws) begin
          HREADY = 1'b0;
          wcnt++;
        end else begin
          wcnt = 0;
          ap_active = 0;
          dp = cur;
          dp_valid = 1;
        end
      end
    end
  end

  // lat: hand-computed cycles from accepted start to done/error.
  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         input logic [1:0] sz, input int nx, input int wst, input int err_el,
                         input int lat, input int kind, input int dbl);
    ws = wst;
    build(s, d, sz, nx, err_el);
    @(posedge HCLK); #1;
    src_addr = s; dst_addr = d; count = n; size = sz; start = 1'b1;
    exp_t = cyc; exp_end = cyc + lat; exp_kind = kind;
    for (int k = 1; k <= lat + 3; k++) begin
      @(posedge HCLK); #1;
      start = (k == dbl);
      if (k == dbl) begin
        src_addr = 32'h1; dst_addr = 32'h0; count = 16'd5; size = 2'b01;
      end
    end
    start = 1'b0;
    chk("xfers_left", 32'(q.size()), 32'h0);
    chk("busy_after", 32'(busy), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    wr32(32'h100, 32'h11223344);
    wr32(32'h104, 32'h55667788);
    wr32(32'h108, 32'h99AABBCC);
    mem[3] = 8'hA5;
    mem[4] = 8'h5A;
    wr32(32'h140, 32'hDEADBEEF);
    wr32(32'h180, 32'h01010101);
    wr32(32'h184, 32'h02020202);
    wr32(32'h3FC, 32'hCAFEF00D);

    #12;
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_flags", {28'h0, busy, done, error, HWRITE}, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);

    run_job(32'h100, 32'h200, 16'd3, 2'b10, 3, 0, -1, 13, 1, 0);
    chk("word_dst0", mem32(32'h200), 32'h11223344);
    chk("word_dst1", mem32(32'h204), 32'h55667788);
    chk("word_dst2", mem32(32'h208), 32'h99AABBCC);

    run_job(32'h003, 32'h011, 16'd2, 2'b00, 2, 0, -1, 9, 1, 0);
    chk("byte_hwdata_last", HWDATA, 32'h5A5A5A5A);
    chk("byte_dst", mem32(32'h010), 32'h005AA500);

    run_job(32'h140, 32'h240, 16'd1, 2'b10, 1, 2, -1, 13, 1, 0);
    chk("wait_dst", mem32(32'h240), 32'hDEADBEEF);

    run_job(32'h101, 32'h220, 16'd1, 2'b01, 0, 0, -1, 1, 2, 0);

    run_job(32'h180, 32'h280, 16'd4, 2'b10, 4, 0, 1, 7, 2, 0);
    chk("hresp_dst0", mem32(32'h280), 32'h01010101);
    chk("hresp_dst1", mem32(32'h284), 32'h00000000);

    run_job(32'h100, 32'h230, 16'd0, 2'b10, 0, 0, -1, 1, 1, 0);

    run_job(32'h100, 32'h2C0, 16'd2, 2'b10, 2, 0, -1, 9, 1, 3);
    chk("dbl_dst1", mem32(32'h2C4), 32'h55667788);

    run_job(32'hFFFFFFFC, 32'h300, 16'd2, 2'b10, 2, 0, -1, 9, 1, 0);
    chk("wrap_dst0", mem32(32'h300), 32'hCAFEF00D);
    chk("wrap_dst1", mem32(32'h304), 32'hA5000000);

    // Reset during the first write data phase of a two-word copy.
    ws = 0;
    build(32'h100, 32'h340, 2'b10, 2, -1);
    @(posedge HCLK); #1;
    src_addr = 32'h100; dst_addr = 32'h340; count = 16'd2; size = 2'b10; start = 1'b1;
    exp_t = cyc; exp_end = cyc + 9; exp_kind = 1;
    @(posedge HCLK); #1;
    start = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'h1);
    chk("pre_rst_hwrite", 32'(HWRITE), 32'h1);
    HRESETn = 1'b0;
    exp_end = cyc - 1;
    q.delete();
    #1;
    chk("mid_rst_htrans", 32'(HTRANS), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_haddr", HADDR, 32'h0);
    chk("mid_rst_hwdata", HWDATA, 32'h0);
    chk("mid_rst_hwrite", 32'(HWRITE), 32'h0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    repeat (3) @(posedge HCLK);
    chk("rst_no_write", mem32(32'h340), 32'h00000000);

    run_job(32'h108, 32'h360, 16'd1, 2'b10, 1, 0, -1, 5, 1, 0);
    chk("post_rst_dst", mem32(32'h360), 32'h99AABBCC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
